// File: rtl/mult_32bit_seq.sv
// Iterative shift-and-add multiplier for MULT/MULTU: 32x32 -> 64-bit HI/LO.
// One adder_32bit add per cycle; sign handled by magnitude multiply plus final negate.

module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        carry_in,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow
);
  always_comb begin
    {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'b0, carry_in};
    overflow = (a[31] == b[31]) && (sum[31] != a[31]);
  end
endmodule

module mult_32bit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [WIDTH-1:0]   ONE   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_W = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    add_b    = acc_lo[0] ? a_mag : '0;
    prod     = {acc_hi, acc_lo};
    prod_neg = ~prod + ONE_W;
  end

  adder_32bit u_add (
    .a         (acc_hi),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout),
    .overflow  ()
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_mag   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // 0x80000000 negates to itself, which reads correctly as unsigned 2^31
            a_mag   <= (is_signed && multiplicand[WIDTH-1]) ? (~multiplicand + ONE) : multiplicand;
            acc_lo  <= (is_signed && multiplier[WIDTH-1])   ? (~multiplier + ONE)   : multiplier;
            neg_res <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc_hi  <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          // 65-bit {carry, sum, acc_lo} shifted right by one into the 64-bit accumulator
          acc_hi <= {add_cout, add_sum[WIDTH-1:1]};
          acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= neg_res ? prod_neg : prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_32bit_seq.sv
// Self-checking bench for mult_32bit_seq: arithmetic reference model with a per-cycle
// compare, literal product vectors, handshake corner cases and randomized traffic.

module tb_mult_32bit_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int n_done = 0;

  mult_32bit_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request completes 33 edges later; requests
  // arriving while one is outstanding are dropped.
  int          m_rem   = 0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;
  logic [63:0] m_pend  = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          {m_hi, m_lo} = m_pend;
        end
      end else if (start) begin
        m_pend = ref_product(multiplicand, multiplier, is_signed);
        m_rem  = 33;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
    end
    if (done) n_done++;
  end

  // Waits (bounded) for done; returns the number of negedges since the call.
  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 100);
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic mul_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    multiplicand = a; multiplier = b; is_signed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(name, cyc);
    cyc++;
    check({name, "_lat"}, 64'(cyc), 64'd34);
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc, d0;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each call starts in the done cycle of the previous one.
    mul_lit("multu_small", 32'd100000, 32'd200000, 1'b0, 32'h0000_0004, 32'hA817_C800);
    mul_lit("multu_max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_lit("mult_minmax", 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'hC000_0000, 32'h8000_0000);
    mul_lit("mult_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    mul_lit("mult_m1m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001);
    mul_lit("mult_neg",    32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    // Start while busy is dropped; result and single done belong to the first request.
    repeat (2) @(negedge clk);
    d0 = n_done;
    multiplicand = 32'd3; multiplier = 32'd5; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    multiplicand = 32'd7; multiplier = 32'd9; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done("ignore", cyc);
    check("ignore_hilo", {hi, lo}, 64'd15);
    repeat (40) @(negedge clk);
    check("ignore_one_done", 64'(n_done - d0), 64'd1);

    // Reset during iteration 10 aborts without a done.
    multiplicand = 32'hFFFF_0000; multiplier = 32'h0001_FFFF; is_signed = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(n_done - d0), 64'd0);
    mul_lit("after_abort", 32'h1234_5678, 32'h8765_4321, 1'b0, 32'h09A0_CD05, 32'h70B8_8D78);

    // Randomized traffic: operands, sign and spurious starts churn while busy.
    for (int unsigned k = 0; k < 40; k++) begin
      multiplicand = pick_op(); multiplier = pick_op(); is_signed = 1'($urandom_range(0, 1));
      start = 1'b1;
      @(negedge clk);
      cyc = 1;
      while (!done && cyc < 100) begin
        multiplicand = $urandom; multiplier = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      if (!done) begin
        errors++;
        $display("FAIL rand_timeout: got no done expected done within 100 cycles");
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
